// File: rtl/multicycle_alu.sv
// multicycle_alu: registered execute-stage ALU with valid/ready handshake.
// Iterative signed MUL/DIV (WIDTH cycles) are built only when ALU_MULDIV_EN is defined.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] firstOperand,
   input  logic [WIDTH-1:0] secondOperand,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] resultHi,
   output logic             zeroFlag
);
`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
   state_t state, state_n;
   logic ld;
   logic [WIDTH-1:0] a, b, sc_res, res_n, rhi_n;
   assign a = firstOperand;
   assign b = secondOperand;
   assign inReady = state == IDLE;
   assign outValid = state == DONE;
   assign sc_res = opcode == 6'd0 ?
                     (funct == 6'd0 ? a + b :
                      funct == 6'd1 ? a - b :
                      funct == 6'd2 ? a & b :
                      funct == 6'd3 ? a | b :
                      funct == 6'd4 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} : '0) :
                   (opcode == 6'd4 || opcode == 6'd5) ? a + b :
                   opcode == 6'd6 ? a - b : '0;
`ifdef ALU_MULDIV_EN
   localparam int CNTW = $clog2(WIDTH) + 1;
   logic [CNTW-1:0] cnt;
   logic [WIDTH-1:0] hi, lo, m, mag_a, mag_b, mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, quo, rem;
   logic [WIDTH:0] mul_sum, div_sh;
   logic [2*WIDTH-1:0] prod;
   logic is_mul, is_div, neg_q, neg_r, div_ok, last;
   assign is_mul = opcode == 6'd0 && funct == 6'd5;
   assign is_div = opcode == 6'd0 && funct == 6'd6;
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;
   // MUL: {hi,lo} shifts right, lo starts as the multiplier and ends as the low product
   assign mul_sum = {1'b0, hi} + {1'b0, {WIDTH{lo[0]}} & m};
   assign mul_hi_n = mul_sum[WIDTH:1];
   assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};
   assign prod = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
   // DIV: hi is the partial remainder, lo shifts the dividend out and quotient bits in
   assign div_sh = {hi, lo[WIDTH-1]};
   assign div_ok = div_sh >= {1'b0, m};
   assign div_hi_n = div_ok ? WIDTH'(div_sh - {1'b0, m}) : div_sh[WIDTH-1:0];
   assign div_lo_n = {lo[WIDTH-2:0], div_ok};
   assign quo = neg_q ? -div_lo_n : div_lo_n;
   assign rem = neg_r ? -div_hi_n : div_hi_n;
   assign last = cnt == CNTW'(WIDTH - 1);
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         m <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (inValid && inReady) begin
         cnt <= '0;
         hi <= '0;
         lo <= is_mul ? mag_b : mag_a;
         m <= is_mul ? mag_a : mag_b;
         neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r <= a[WIDTH-1];
      end else if (state == MUL || state == DIV) begin
         cnt <= cnt + 1'b1;
         hi <= state == MUL ? mul_hi_n : div_hi_n;
         lo <= state == MUL ? mul_lo_n : div_lo_n;
      end
`endif
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      ld = 1'b0;
      res_n = result;
      rhi_n = resultHi;
      case (state)
         IDLE: if (inValid) begin
`ifdef ALU_MULDIV_EN
            if (is_mul) state_n = MUL;
            else if (is_div && b != '0) state_n = DIV;
            else begin
               state_n = DONE;
               ld = 1'b1;
               res_n = is_div ? '1 : sc_res;
               rhi_n = is_div ? a : '0;
            end
`else
            state_n = DONE;
            ld = 1'b1;
            res_n = sc_res;
            rhi_n = '0;
`endif
         end
`ifdef ALU_MULDIV_EN
         MUL: if (last) begin
            state_n = DONE;
            ld = 1'b1;
            res_n = prod[WIDTH-1:0];
            rhi_n = prod[2*WIDTH-1:WIDTH];
         end
         DIV: if (last) begin
            state_n = DONE;
            ld = 1'b1;
            res_n = quo;
            rhi_n = rem;
         end
`endif
         DONE: if (outReady) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         result <= '0;
         resultHi <= '0;
         zeroFlag <= 1'b0;
      end else if (ld) begin
         result <= res_n;
         resultHi <= rhi_n;
         zeroFlag <= res_n == '0;
      end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu (WIDTH=32 plus a WIDTH=8 instance).
// MUL/DIV vectors are exercised only when ALU_MULDIV_EN is defined.
module tb_multicycle_alu;
   logic clk = 0, resetN = 1, inValid = 0, outReady = 0;
   logic inReady, outValid, zeroFlag;
   logic [5:0] opcode = 0, funct = 0;
   logic [31:0] firstOperand = 0, secondOperand = 0, result, resultHi;
   logic iv8 = 0, rdy8, ov8, z8;
   logic [7:0] a8 = 0, b8 = 0, r8, h8;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   multicycle_alu #(.WIDTH(32)) dut (
      .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
      .opcode(opcode), .funct(funct), .firstOperand(firstOperand), .secondOperand(secondOperand),
      .outValid(outValid), .outReady(outReady), .result(result), .resultHi(resultHi), .zeroFlag(zeroFlag));

   multicycle_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .resetN(resetN), .inValid(iv8), .inReady(rdy8),
      .opcode(opcode), .funct(funct), .firstOperand(a8), .secondOperand(b8),
      .outValid(ov8), .outReady(1'b1), .result(r8), .resultHi(h8), .zeroFlag(z8));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      outReady = 1;
      @(posedge clk);
      #1 outReady = 0;
      chk({tag, "_idle_rdy"}, inReady, 1'b1);
      chk({tag, "_idle_ov"}, outValid, 1'b0);
   endtask

   // Issue one request, scramble the inputs after accept, wait for outValid and check.
   task automatic op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [31:0] eh, input logic ez,
                     input int elat, input bit hold = 0);
      int lat = 1;
      logic busy = 0;
      @(negedge clk);
      chk({tag, "_rdy"}, inReady, 1'b1);
      opcode = opc; funct = fn; firstOperand = a; secondOperand = b; inValid = 1;
      @(posedge clk);
      #1 inValid = 0;
      opcode = 6'($urandom); funct = 6'($urandom);
      firstOperand = $urandom; secondOperand = $urandom;
      while (!outValid && lat < 200) begin
         if (inReady) busy = 1;
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_busy_rdy"}, busy, 1'b0);
      chk({tag, "_res"}, result, er);
      chk({tag, "_hi"}, resultHi, eh);
      chk({tag, "_zf"}, zeroFlag, ez);
      if (!hold) release_out(tag);
   endtask

   initial begin
      #2 resetN = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res", result, 32'h0);
      chk("rst_hi", resultHi, 32'h0);
      chk("rst_zf", zeroFlag, 1'b0);
      chk("rst_ov", outValid, 1'b0);
      chk("rst_rdy", inReady, 1'b1);
      @(negedge clk) resetN = 1;

`ifdef ALU_MULDIV_EN
      // reset in the middle of a MUL discards it immediately
      @(negedge clk);
      opcode = 0; funct = 5; firstOperand = 7; secondOperand = 3; inValid = 1;
      @(posedge clk);
      #1 inValid = 0;
      repeat (9) @(posedge clk);
      #1 resetN = 0;
      #1;
      chk("rmul_res", result, 32'h0);
      chk("rmul_hi", resultHi, 32'h0);
      chk("rmul_ov", outValid, 1'b0);
      chk("rmul_rdy", inReady, 1'b1);
      @(negedge clk) resetN = 1;
`endif
      op("add_zero", 0, 0, 5, 32'hFFFFFFFB, 0, 0, 1, 1);
      op("add", 0, 0, 2, 3, 5, 0, 0, 1);
      op("sub", 0, 1, 3, 5, 32'hFFFFFFFE, 0, 0, 1);
      op("and", 0, 2, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 1);
      op("or", 0, 3, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 1);
      op("slt_t", 0, 4, 32'hFFFFFFFF, 1, 1, 0, 0, 1);
      op("slt_f", 0, 4, 1, 32'hFFFFFFFF, 0, 0, 1, 1);
      op("bad_fn", 0, 7, 9, 4, 0, 0, 1, 1);
      op("lw", 4, 0, 10, 32'hFFFFFFFD, 7, 0, 0, 1);
      op("sw", 5, 9, 32'h1000, 32'h20, 32'h1020, 0, 0, 1);
      op("beq_eq", 6, 0, 3, 3, 0, 0, 1, 1);
      op("beq_ne", 6, 0, 5, 3, 2, 0, 0, 1);
      op("bad_op", 9, 0, 5, 3, 0, 0, 1, 1);
`ifdef ALU_MULDIV_EN
      op("mul_neg", 0, 5, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 33);
      op("mul_nn", 0, 5, 32'hFFFFFFFB, 32'hFFFFFFFC, 20, 0, 0, 33);
      op("mul_big", 0, 5, 32'h80000000, 32'h80000000, 0, 32'h40000000, 1, 33);
      op("mul_z", 0, 5, 0, 5, 0, 0, 1, 33);
      op("div_neg", 0, 6, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
      op("div_nd", 0, 6, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 33);
      op("div_z", 0, 6, 100, 0, 32'hFFFFFFFF, 100, 0, 1);
      op("div_ovf", 0, 6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33);
`else
      op("mul_off", 0, 5, 6, 7, 0, 0, 1, 1);
      op("div_off", 0, 6, 100, 0, 0, 0, 1, 1);
`endif
      // backpressure: hold DONE for 5 cycles while new requests are offered
      op("bp", 0, 0, 2, 3, 5, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         opcode = 0; funct = 1; firstOperand = 9; secondOperand = 1; inValid = 1;
         @(posedge clk);
         #1 inValid = 0;
         chk("bp_res", result, 32'h5);
         chk("bp_ov", outValid, 1'b1);
         chk("bp_rdy", inReady, 1'b0);
      end
      release_out("bp");
      op("bp_next", 0, 1, 9, 1, 8, 0, 0, 1);
      // reset while a result is held in DONE
      op("rdone", 0, 3, 6, 1, 7, 0, 0, 1, 1);
      @(negedge clk) resetN = 0;
      #1;
      chk("rdone_res", result, 32'h0);
      chk("rdone_ov", outValid, 1'b0);
      chk("rdone_rdy", inReady, 1'b1);
      @(negedge clk) resetN = 1;
      // WIDTH=8 instance wraps modulo 2^8
      @(negedge clk);
      chk("w8_rdy", rdy8, 1'b1);
      opcode = 0; funct = 0; a8 = 8'h7F; b8 = 8'h01; iv8 = 1;
      @(posedge clk);
      #1 iv8 = 0;
      chk("w8_ov", ov8, 1'b1);
      chk("w8_res", r8, 8'h80);
      chk("w8_hi", h8, 8'h00);
      chk("w8_zf", z8, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
